bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16, meaning the maximum number of consecutive cycles one master may own the bus; only used with BUS_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1 bit: single bus clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port m_req_, input, 4 bits: bus request from masters 0..3, active-low.
REQ-005 SHALL have port m_grnt_, output, 4 bits: bus grant to masters 0..3, active-low, at most one bit low.
REQ-006 SHALL have port owner, output, 2 bits: index of the master currently granted; holds the last owner while idle.
REQ-007 SHALL have port busy, output, 1 bit: high while any grant is asserted.
REQ-008 SHALL have port preempt, output, 1 bit: one-cycle pulse when ownership is forcibly rotated.

Function
REQ-009 SHALL implement a two-state machine, IDLE (no grant) and GRANT (one grant asserted), with all outputs registered.
REQ-010 SHALL, in IDLE with any m_req_ bit low at a clock edge, enter GRANT with that grant low from the next cycle (1-cycle latency).
REQ-011 SHALL pick the winner round-robin: search from owner+1 upward modulo 4 (3 wraps to 0); the first active request wins.
REQ-012 SHALL, in GRANT, keep the grant unchanged while the owner's m_req_ stays low, regardless of other requests, unless REQ-020 applies.
REQ-013 SHALL, in GRANT when the owner's m_req_ is sampled high with another request low, move the grant directly to the round-robin winner on the next edge, with no idle cycle.
REQ-014 SHALL, in GRANT when the owner's m_req_ is sampled high with no other request low, return to IDLE, drive m_grnt_ to 4'b1111 and hold owner.
REQ-015 SHALL never drive two m_grnt_ bits low in the same cycle, including on switch cycles.
REQ-016 SHALL select the round-robin winner when a release and new requests arrive in the same cycle; the releasing master is eligible only if no other master requests.
REQ-017 SHALL keep busy equal to (m_grnt_ != 4'b1111), registered together with m_grnt_.

Reset
REQ-018 SHALL, while reset is low, force state=IDLE, m_grnt_=4'b1111, owner=2'd3, busy=0, preempt=0 and hold count=0, so that master 0 has first priority after reset.
REQ-019 SHALL, on reset assertion mid-grant, drop the grant immediately (asynchronously); after release, arbitrate fresh from IDLE.

Configuration
REQ-020 SHALL, with BUS_ARB_TIMEOUT_EN defined, count consecutive GRANT cycles of the current owner (counter clears on any owner change or on IDLE). When the count reaches HOLD_MAX-1 and another master requests, the grant SHALL rotate to the round-robin winner on the next edge with preempt=1 for that one cycle. When no other master requests, the counter SHALL saturate and the owner SHALL keep the bus.
REQ-021 SHALL, without BUS_ARB_TIMEOUT_EN, omit the counter: the owner holds the bus until it releases m_req_, and preempt SHALL be tied to 0.

Verification
REQ-022 SHALL cover reset then m_req_=4'b1010 -> m_grnt_=4'b1110 one cycle later, owner=0, busy=1.
REQ-023 SHALL cover owner 0 releasing while m_req_=4'b0101 (masters 1 and 3 requesting) -> next cycle m_grnt_=4'b1101, owner=1, no cycle with all grants high.
REQ-024 SHALL cover owner 3 releasing with masters 0 and 2 requesting -> grant wraps to master 0 (m_grnt_=4'b1110).
REQ-025 SHALL cover sole requester 2 releasing -> m_grnt_=4'b1111, busy=0, owner stays 2; a new request from 2 is granted again after 1 cycle.
REQ-026 SHALL cover, with BUS_ARB_TIMEOUT_EN and HOLD_MAX=16, master 1 holding the bus while master 2 requests continuously -> grant moves to master 2 after 16 grant cycles, with preempt pulsing once; without the macro -> master 1 keeps the grant indefinitely and preempt stays 0.
REQ-027 SHALL cover reset asserted during a grant to master 1 -> m_grnt_=4'b1111 immediately; after reset release with all masters requesting -> master 0 is granted first.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with active-low request/grant and registered outputs.
// Optional hold-time preemption is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] m_req_,
  output logic [3:0] m_grnt_,
  output logic [1:0] owner,
  output logic       busy,
  output logic       preempt
);

  if (HOLD_MAX == 0) begin : g_hold_max_invalid
    $error("bus_rr_arbiter: HOLD_MAX must be at least 1");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [3:0] grnt_q, grnt_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;

  logic [3:0] req;
  logic [1:0] cand;
  logic [1:0] win;
  logic       win_vld;

  assign req = ~m_req_;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          preempt_q, preempt_d;
  logic          others;

  assign others = |(req & ~(4'b0001 << owner_q));
`endif

  // Search starts just past the current owner; the owner itself is tried last.
  always_comb begin
    win     = owner_q;
    win_vld = 1'b0;
    cand    = owner_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = owner_q + 2'(i);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          owner_d = win;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          // Owner released: its own request bit is clear, so any winner is another master.
          if (win_vld) begin
            owner_d = win;
          end else begin
            state_d = IDLE;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (others && (cnt_q == CNT_MAX)) begin
          owner_d   = win;
          cnt_d     = '0;
          preempt_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    grnt_d = (state_d == GRANT) ? ~(4'b0001 << owner_d) : '1;
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grnt_q    <= '1;
      owner_q   <= 2'd3;
      busy_q    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grnt_q    <= grnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
`endif
    end
  end

  assign m_grnt_ = grnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_bus_rr_arbiter;

  localparam int TB_HOLD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] m_req_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_owner;
  bit m_busy;
  int m_held;
  bit m_pre;

  bus_rr_arbiter #(.HOLD_MAX(TB_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req_  (m_req_),
    .m_grnt_ (m_grnt_),
    .owner   (owner),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 3;
    m_busy  = 0;
    m_held  = 0;
    m_pre   = 0;
  endtask

  task automatic model_edge(input logic [3:0] req_n);
    logic [3:0] r;
    int w;
    bit others;
    r = ~req_n;
    m_pre = 0;
    others = 0;
    for (int k = 0; k < 4; k++) if (k != m_owner && r[k]) others = 1;
    if (!m_busy) begin
      w = rr_pick(r, m_owner);
      if (w >= 0) begin m_busy = 1; m_owner = w; m_held = 1; end
    end else if (!r[m_owner]) begin
      w = rr_pick(r, m_owner);
      if (w >= 0) begin m_owner = w; m_held = 1; end
      else begin m_busy = 0; m_held = 0; end
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      if (others && m_held >= TB_HOLD) begin
        m_owner = rr_pick(r, m_owner);
        m_held  = 1;
        m_pre   = 1;
      end else begin
        m_held++;
      end
`else
      m_held++;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(m_req_);
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    m_req_ = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (m_grnt_ !== 4'b1111) begin n_fail++; $display("FAIL reset_grnt got=%b want=1111", m_grnt_); end
    n_checks++;
    if (owner !== 2'd3) begin n_fail++; $display("FAIL reset_owner got=%0d want=3", owner); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++;
    if (preempt !== 1'b0) begin n_fail++; $display("FAIL reset_preempt got=%b want=0", preempt); end
  endtask

  task automatic test_first_grant();
    m_req_ = 4'b1010;
    tick();
    n_checks++;
    if ({m_grnt_, owner, busy, preempt} !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_grant got grnt=%b owner=%0d busy=%b pre=%b want 1110/0/1/0", m_grnt_, owner, busy, preempt);
    end
  endtask

  task automatic test_handoff();
    m_req_ = 4'b0101;
    tick();
    n_checks++;
    if ({m_grnt_, owner, busy} !== {4'b1101, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL handoff got grnt=%b owner=%0d busy=%b want 1101/1/1", m_grnt_, owner, busy);
    end
  endtask

  task automatic test_wrap();
    m_req_ = 4'b0111;
    tick();
    n_checks++;
    if ({m_grnt_, owner} !== {4'b0111, 2'd3}) begin
      n_fail++;
      $display("FAIL wrap_setup got grnt=%b owner=%0d want 0111/3", m_grnt_, owner);
    end
    m_req_ = 4'b1010;
    tick();
    n_checks++;
    if ({m_grnt_, owner, busy} !== {4'b1110, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap got grnt=%b owner=%0d busy=%b want 1110/0/1", m_grnt_, owner, busy);
    end
  endtask

  task automatic test_idle_return();
    m_req_ = 4'b1011;
    tick();
    n_checks++;
    if ({m_grnt_, owner} !== {4'b1011, 2'd2}) begin
      n_fail++;
      $display("FAIL sole2_grant got grnt=%b owner=%0d want 1011/2", m_grnt_, owner);
    end
    m_req_ = 4'b1111;
    repeat (2) begin
      tick();
      n_checks++;
      if ({m_grnt_, owner, busy} !== {4'b1111, 2'd2, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_hold got grnt=%b owner=%0d busy=%b want 1111/2/0", m_grnt_, owner, busy);
      end
    end
    m_req_ = 4'b1011;
    tick();
    n_checks++;
    if ({m_grnt_, owner, busy} !== {4'b1011, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL regrant2 got grnt=%b owner=%0d busy=%b want 1011/2/1", m_grnt_, owner, busy);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int exp_owner;
    bit exp_pre;
    apply_reset();
    pulses = 0;
    m_req_ = 4'b1001;
    for (int t = 1; t <= 24; t++) begin
      tick();
`ifdef BUS_ARB_TIMEOUT_EN
      exp_owner = (t <= TB_HOLD) ? 1 : 2;
      exp_pre   = (t == TB_HOLD + 1);
`else
      exp_owner = 1;
      exp_pre   = 0;
`endif
      if (preempt === 1'b1) pulses++;
      n_checks++;
      if ({owner, busy, preempt} !== {2'(exp_owner), 1'b1, exp_pre}) begin
        n_fail++;
        $display("FAIL timeout_t%0d got owner=%0d busy=%b pre=%b want %0d/1/%b", t, owner, busy, preempt, exp_owner, exp_pre);
      end
    end
    n_checks++;
`ifdef BUS_ARB_TIMEOUT_EN
    if (pulses != 1) begin n_fail++; $display("FAIL preempt_pulses got=%0d want=1", pulses); end
`else
    if (pulses != 0) begin n_fail++; $display("FAIL preempt_pulses got=%0d want=0", pulses); end
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    m_req_ = 4'b1101;
    tick();
    n_checks++;
    if ({m_grnt_, owner} !== {4'b1101, 2'd1}) begin
      n_fail++;
      $display("FAIL async_setup got grnt=%b owner=%0d want 1101/1", m_grnt_, owner);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({m_grnt_, owner, busy, preempt} !== {4'b1111, 2'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_drop got grnt=%b owner=%0d busy=%b pre=%b want 1111/3/0/0", m_grnt_, owner, busy, preempt);
    end
    m_req_ = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_checks++;
    if ({m_grnt_, owner, busy} !== {4'b1110, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_restart got grnt=%b owner=%0d busy=%b want 1110/0/1", m_grnt_, owner, busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] req_v;
    logic [3:0] eg;
    apply_reset();
    req_v = 4'b1111;
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) req_v[b] = ~req_v[b];
      m_req_ = req_v;
      tick();
      eg = 4'b1111;
      if (m_busy) eg[m_owner] = 1'b0;
      n_checks++;
      if ({m_grnt_, owner, busy, preempt} !== {eg, 2'(m_owner), m_busy, m_pre}) begin
        n_fail++;
        $display("FAIL random_c%0d req=%b got %b/%0d/%b/%b want %b/%0d/%b/%b", c, req_v,
                 m_grnt_, owner, busy, preempt, eg, m_owner, m_busy, m_pre);
      end
      n_checks++;
      if ($countones(~m_grnt_) > 1) begin
        n_fail++;
        $display("FAIL onehot_c%0d got grnt=%b want at most one low bit", c, m_grnt_);
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    m_req_ = 4'b1111;
    model_reset();
    test_reset();
    test_first_grant();
    test_handoff();
    test_wrap();
    test_idle_return();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
